// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access unit: access widths, lane indices,
// FSM states and the access fault rule.
package mem_access_unit_pkg;

    localparam logic [1:0] MEM_LEN_WORD = 2'b00;
    localparam logic [1:0] MEM_LEN_HALF = 2'b01;
    localparam logic [1:0] MEM_LEN_BYTE = 2'b10;

    localparam logic [1:0] BYTE_IDX_0 = 2'b00;
    localparam logic [1:0] BYTE_IDX_1 = 2'b01;
    localparam logic [1:0] BYTE_IDX_2 = 2'b10;
    localparam logic [1:0] BYTE_IDX_3 = 2'b11;

    localparam logic HALF_IDX_LO = 1'b0;
    localparam logic HALF_IDX_HI = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RD_WAIT = 2'b01,
        ST_RESP    = 2'b10
    } mau_state_t;

    // Width code 2'b11 falls into the word case on purpose.
    function automatic logic access_fault(input logic [31:0] addr,
                                          input logic [1:0]  len,
                                          input logic [31:0] ram_top);
        logic misaligned;
        case (len)
            MEM_LEN_HALF: misaligned = addr[0];
            MEM_LEN_BYTE: misaligned = 1'b0;
            default:      misaligned = (addr[1:0] != 2'b00);
        endcase
        return misaligned | (addr >= ram_top);
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Picks the addressed byte/half lane out of a RAM word and extends it to 32 bits.
module load_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] ram_word,
    input  logic [1:0]  addr,
    input  logic [1:0]  len,
    input  logic        unsigned_ld,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection and zero/sign extension.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        result = 32'h0000_0000;
        case (addr)
            BYTE_IDX_0: byte_s = ram_word[7:0];
            BYTE_IDX_1: byte_s = ram_word[15:8];
            BYTE_IDX_2: byte_s = ram_word[23:16];
            BYTE_IDX_3: byte_s = ram_word[31:24];
            default:    byte_s = 8'h00;
        endcase
        if (addr[1] == HALF_IDX_HI) begin
            half_s = ram_word[31:16];
        end else begin
            half_s = ram_word[15:0];
        end
        case (len)
            MEM_LEN_HALF: result = {(unsigned_ld ? 16'h0000 : {16{half_s[15]}}), half_s};
            MEM_LEN_BYTE: result = {(unsigned_ld ? 24'h00_0000 : {24{byte_s[7]}}), byte_s};
            default:      result = ram_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between execute and write-back: one outstanding access,
// alignment/range faulting, registered RAM read with echoed-address check.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter logic [31:0] RAM_BASE = 32'h0000_4000,
    parameter logic [31:0] RAM_TOP  = 32'h0000_8000
) (
    input  logic        i_Clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [1:0]  i_req_len,
    input  logic        i_req_unsigned,
    input  logic [4:0]  i_req_rd,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output logic [4:0]  o_rsp_rd,
    output logic        o_rsp_err,
    output logic        o_ram_we,
    output logic [1:0]  o_ram_mem_len,
    output logic [31:0] o_ram_w_addr,
    output logic [31:0] o_ram_w_data,
    output logic [31:0] o_ram_r_addr,
    input  logic [31:0] i_ram_r_data,
    input  logic [31:0] i_ram_r_addr
);

    mau_state_t  state_r;
    logic [31:0] addr_r;
    logic [1:0]  len_r;
    logic        unsigned_r;
    logic [4:0]  rd_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_data_r;
    logic [4:0]  rsp_rd_r;
    logic        rsp_err_r;

    logic        accept_s;
    logic        fault_s;
    logic        store_s;
    logic        load_s;
    logic [31:0] aligned_s;

    // RAM_BASE documents the window; accesses are only bounded from above.
    logic unused_ram_base_s;
    assign unused_ram_base_s = ^RAM_BASE;

    assign o_req_ready = i_reset & (state_r == ST_IDLE);
    assign accept_s    = i_req_valid & o_req_ready;
    assign fault_s     = access_fault(i_req_addr, i_req_len, RAM_TOP);
    assign store_s     = accept_s & i_req_we & ~fault_s;
    assign load_s      = accept_s & ~i_req_we & ~fault_s;

    // RAM ports are driven only in a non-faulting accept cycle, zero otherwise.
    always_comb begin
        o_ram_we      = 1'b0;
        o_ram_mem_len = 2'b00;
        o_ram_w_addr  = 32'h0000_0000;
        o_ram_w_data  = 32'h0000_0000;
        o_ram_r_addr  = 32'h0000_0000;
        if (store_s) begin
            o_ram_we      = 1'b1;
            o_ram_mem_len = i_req_len;
            o_ram_w_addr  = i_req_addr;
            o_ram_w_data  = i_req_wdata;
        end else if (load_s) begin
            o_ram_r_addr  = i_req_addr;
        end else begin
            o_ram_we      = 1'b0;
        end
    end

    load_align u_load_align (
        .ram_word    (i_ram_r_data),
        .addr        (addr_r[1:0]),
        .len         (len_r),
        .unsigned_ld (unsigned_r),
        .result      (aligned_s)
    );

    // Request FSM with registered response outputs.
    always_ff @(posedge i_Clk) begin
        if (!i_reset) begin
            state_r     <= ST_IDLE;
            addr_r      <= 32'h0000_0000;
            len_r       <= 2'b00;
            unsigned_r  <= 1'b0;
            rd_r        <= 5'd0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 32'h0000_0000;
            rsp_rd_r    <= 5'd0;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (fault_s || i_req_we) begin
                            rsp_valid_r <= 1'b1;
                            rsp_data_r  <= 32'h0000_0000;
                            rsp_rd_r    <= i_req_rd;
                            rsp_err_r   <= fault_s;
                            state_r     <= ST_RESP;
                        end else begin
                            addr_r      <= i_req_addr;
                            len_r       <= i_req_len;
                            unsigned_r  <= i_req_unsigned;
                            rd_r        <= i_req_rd;
                            state_r     <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    // An echoed address that differs means the RAM answered another access.
                    rsp_valid_r <= 1'b1;
                    rsp_rd_r    <= rd_r;
                    if (i_ram_r_addr != addr_r) begin
                        rsp_err_r  <= 1'b1;
                        rsp_data_r <= 32'h0000_0000;
                    end else begin
                        rsp_err_r  <= 1'b0;
                        rsp_data_r <= aligned_s;
                    end
                    state_r <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_rsp_valid = rsp_valid_r;
    assign o_rsp_data  = rsp_data_r;
    assign o_rsp_rd    = rsp_rd_r;
    assign o_rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed checks of mem_access_unit against a byte-addressed
// reference memory and the access rules (fault, latency, extension, handshake).
module tb_mem_access_unit;

    logic        i_Clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [31:0] i_req_addr = 32'h0;
    logic [31:0] i_req_wdata = 32'h0;
    logic [1:0]  i_req_len = 2'b00;
    logic        i_req_unsigned = 1'b0;
    logic [4:0]  i_req_rd = 5'd0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b0;
    logic [31:0] o_rsp_data;
    logic [4:0]  o_rsp_rd;
    logic        o_rsp_err;
    logic        o_ram_we;
    logic [1:0]  o_ram_mem_len;
    logic [31:0] o_ram_w_addr;
    logic [31:0] o_ram_w_data;
    logic [31:0] o_ram_r_addr;
    logic [31:0] i_ram_r_data = 32'h0;
    logic [31:0] i_ram_r_addr = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;
    logic        corrupt_echo = 1'b0;
    logic [31:0] ram [4096];
    logic [7:0]  ref_mem [16384];
    logic [31:0] got_data;

    mem_access_unit dut (
        .i_Clk(i_Clk), .i_reset(i_reset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .i_req_len(i_req_len), .i_req_unsigned(i_req_unsigned), .i_req_rd(i_req_rd),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_data(o_rsp_data), .o_rsp_rd(o_rsp_rd), .o_rsp_err(o_rsp_err),
        .o_ram_we(o_ram_we), .o_ram_mem_len(o_ram_mem_len),
        .o_ram_w_addr(o_ram_w_addr), .o_ram_w_data(o_ram_w_data),
        .o_ram_r_addr(o_ram_r_addr), .i_ram_r_data(i_ram_r_data), .i_ram_r_addr(i_ram_r_addr)
    );

    always #5 i_Clk = ~i_Clk;

    // Registered RAM: byte/half/word writes, read data and echoed address one cycle later.
    always @(posedge i_Clk) begin
        if (o_ram_we) begin
            if (o_ram_mem_len == 2'b10)
                ram[o_ram_w_addr[13:2]][8*o_ram_w_addr[1:0] +: 8] <= o_ram_w_data[7:0];
            else if (o_ram_mem_len == 2'b01)
                ram[o_ram_w_addr[13:2]][16*o_ram_w_addr[1] +: 16] <= o_ram_w_data[15:0];
            else
                ram[o_ram_w_addr[13:2]] <= o_ram_w_data;
        end
        i_ram_r_data <= ram[o_ram_r_addr[13:2]];
        i_ram_r_addr <= corrupt_echo ? (o_ram_r_addr ^ 32'h0000_0004) : o_ram_r_addr;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int access_size(input logic [1:0] len);
        return (len == 2'b01) ? 2 : ((len == 2'b10) ? 1 : 4);
    endfunction

    // One full transaction: expectation from the reference memory, then drive and compare.
    task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] len, input logic uns, input logic [4:0] rd);
        int size, cyc, base;
        logic flt, exp_err;
        logic [31:0] exp_data, v;
        size = access_size(len);
        flt  = ((addr % size) != 0) || (addr >= 32'h0000_8000);
        base = int'(addr) - 32'h4000;
        exp_err  = flt || (!we && corrupt_echo);
        exp_data = 32'h0;
        if (!exp_err && !we) begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | ({24'h0, ref_mem[base + i]} << (8 * i));
            if (!uns && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
            exp_data = v;
        end
        if (we && !flt)
            for (int i = 0; i < size; i++) ref_mem[base + i] = wdata[8*i +: 8];

        cyc = 0;
        while (!o_req_ready && cyc < 20) begin @(posedge i_Clk); #1; cyc++; end
        check_eq("req_ready", {31'h0, o_req_ready}, 32'h1);
        i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr; i_req_wdata = wdata;
        i_req_len = len; i_req_unsigned = uns; i_req_rd = rd;
        #1;
        check_eq("ram_we", {31'h0, o_ram_we}, {31'h0, we && !flt});
        check_eq("ram_r_addr", o_ram_r_addr, (!we && !flt) ? addr : 32'h0);
        if (we && !flt) begin
            check_eq("ram_w_addr", o_ram_w_addr, addr);
            check_eq("ram_w_data", o_ram_w_data, wdata);
        end
        @(posedge i_Clk); #1;
        i_req_valid = 1'b0;
        cyc = 1;
        while (!o_rsp_valid && cyc < 10) begin @(posedge i_Clk); #1; cyc++; end
        check_eq("rsp_latency", cyc, (we || flt) ? 32'd1 : 32'd2);
        check_eq("rsp_data", o_rsp_data, exp_data);
        check_eq("rsp_err", {31'h0, o_rsp_err}, {31'h0, exp_err});
        check_eq("rsp_rd", {27'h0, o_rsp_rd}, {27'h0, rd});
        got_data = o_rsp_data;
        i_rsp_ready = 1'b1;
        @(posedge i_Clk); #1;
        i_rsp_ready = 1'b0;
        check_eq("rsp_drop", {31'h0, o_rsp_valid}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
        for (int i = 0; i < 16384; i++) ref_mem[i] = 8'h00;

        repeat (3) @(posedge i_Clk);
        #1;
        check_eq("reset_valid", {31'h0, o_rsp_valid}, 32'h0);
        check_eq("reset_ready", {31'h0, o_req_ready}, 32'h0);
        check_eq("reset_we", {31'h0, o_ram_we}, 32'h0);
        check_eq("reset_data", o_rsp_data, 32'h0);
        i_reset = 1'b1;
        @(posedge i_Clk); #1;
        check_eq("idle_ready", {31'h0, o_req_ready}, 32'h1);

        // Directed byte and half extension cases.
        run_req(1'b1, 32'h4010, 32'hDEAD_BEEF, 2'b00, 1'b0, 5'd1);
        run_req(1'b0, 32'h4013, 32'h0, 2'b10, 1'b1, 5'd2);
        check_eq("byte_u_const", got_data, 32'h0000_00DE);
        run_req(1'b1, 32'h4002, 32'h0000_8001, 2'b01, 1'b0, 5'd3);
        run_req(1'b0, 32'h4002, 32'h0, 2'b01, 1'b0, 5'd4);
        check_eq("half_s_const", got_data, 32'hFFFF_8001);
        run_req(1'b0, 32'h4002, 32'h0, 2'b01, 1'b1, 5'd5);
        check_eq("half_u_const", got_data, 32'h0000_8001);
        // Faults: misaligned word, top of window, misaligned half store, width code 11.
        run_req(1'b0, 32'h4006, 32'h0, 2'b00, 1'b0, 5'd6);
        run_req(1'b0, 32'h8000, 32'h0, 2'b10, 1'b0, 5'd7);
        run_req(1'b1, 32'h4011, 32'h1234_5678, 2'b01, 1'b0, 5'd8);
        run_req(1'b0, 32'h4012, 32'h0, 2'b11, 1'b0, 5'd9);
        run_req(1'b0, 32'h7FFC, 32'h0, 2'b00, 1'b0, 5'd10);
        // Echoed address mismatch.
        corrupt_echo = 1'b1;
        run_req(1'b0, 32'h4010, 32'h0, 2'b00, 1'b0, 5'd11);
        corrupt_echo = 1'b0;

        // Response held off while a new request waits.
        run_req(1'b1, 32'h4020, 32'h1234_5678, 2'b00, 1'b0, 5'd12);
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = 32'h4024; i_req_wdata = 32'hCAFE_F00D;
        i_req_len = 2'b00; i_req_rd = 5'd13;
        for (int i = 0; i < 4; i++) ref_mem[32'h24 + i] = i_req_wdata[8*i +: 8];
        @(posedge i_Clk); #1;
        i_req_we = 1'b0; i_req_addr = 32'h4024; i_req_rd = 5'd14; i_req_unsigned = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check_eq("hold_valid", {31'h0, o_rsp_valid}, 32'h1);
            check_eq("hold_rd", {27'h0, o_rsp_rd}, 32'd13);
            check_eq("hold_ready", {31'h0, o_req_ready}, 32'h0);
            check_eq("hold_raddr", o_ram_r_addr, 32'h0);
            @(posedge i_Clk); #1;
        end
        i_rsp_ready = 1'b1;
        @(posedge i_Clk); #1;
        i_rsp_ready = 1'b0;
        check_eq("release_ready", {31'h0, o_req_ready}, 32'h1);
        check_eq("release_raddr", o_ram_r_addr, 32'h4024);
        @(posedge i_Clk); #1;
        i_req_valid = 1'b0;
        @(posedge i_Clk); #1;
        check_eq("held_rsp_valid", {31'h0, o_rsp_valid}, 32'h1);
        check_eq("held_rsp_data", o_rsp_data, 32'hCAFE_F00D);
        check_eq("held_rsp_rd", {27'h0, o_rsp_rd}, 32'd14);
        i_rsp_ready = 1'b1;
        @(posedge i_Clk); #1;
        i_rsp_ready = 1'b0;

        // Reset while waiting for read data discards the load.
        i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 32'h4010; i_req_len = 2'b00; i_req_rd = 5'd15;
        @(posedge i_Clk); #1;
        i_req_valid = 1'b0;
        i_reset = 1'b0;
        @(posedge i_Clk); #1;
        check_eq("rst_valid", {31'h0, o_rsp_valid}, 32'h0);
        check_eq("rst_ready", {31'h0, o_req_ready}, 32'h0);
        check_eq("rst_we", {31'h0, o_ram_we}, 32'h0);
        check_eq("rst_data", o_rsp_data, 32'h0);
        check_eq("rst_rd", {27'h0, o_rsp_rd}, 32'h0);
        check_eq("rst_err", {31'h0, o_rsp_err}, 32'h0);
        i_reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge i_Clk); #1;
            check_eq("post_rst_valid", {31'h0, o_rsp_valid}, 32'h0);
            check_eq("post_rst_ready", {31'h0, o_req_ready}, 32'h1);
        end

        // Random traffic in a small window plus occasional out-of-range addresses.
        for (int n = 0; n < 120; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 5) == 0) a = 32'h8000 + $urandom_range(0, 15);
            else a = 32'h4000 + $urandom_range(0, 31);
            run_req(1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
